uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_hold_slot.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART TX arbiter.
package uart_tx_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int NUM_REQ        = 2;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Round-robin pick: a lone requester always wins, a tie goes to whoever
  // was not granted last.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] vld, input logic last);
    if (vld == 2'b11) return ~last;
    return vld[1] ? REQ_DBG : REQ_CPU;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes plus the transmitter-side start/busy bus.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data0;
  logic                  valid0;
  logic                  ready0;
  logic [DATA_WIDTH-1:0] data1;
  logic                  valid1;
  logic                  ready1;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  grant_id;
  logic                  active;
  logic                  tx_err;

  // Arbiter side
  modport slave (
    input  data0, valid0, data1, valid1, tx_busy,
    output ready0, ready1, tx_data, tx_start, grant_id, active, tx_err
  );

  // Requesters + transmitter side
  modport master (
    output data0, valid0, data1, valid1, tx_busy,
    input  ready0, ready1, tx_data, tx_start, grant_id, active, tx_err
  );
endinterface

// File: rtl/uart_tx_hold_slot.sv
// Single-entry valid/ready holding register. ready is the registered
// inverse of the occupancy flag, so there is no combinational bypass.
module uart_tx_hold_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  ready,
  input  logic                  consume,
  output logic                  hold_valid,
  output logic [DATA_WIDTH-1:0] hold_data
);

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Capture when empty, release when the arbiter takes the byte.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (consume) begin
      vld_d = 1'b0;
    end else if (in_valid && !vld_q) begin
      vld_d  = 1'b1;
      data_d = in_data;
    end
  end

  // Occupancy and byte registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign ready      = ~vld_q;
  assign hold_valid = vld_q;
  assign hold_data  = data_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that sequences one UART transmitter through
// start / wait-for-busy / wait-for-done for two byte producers.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] in_data, hold_data;
  logic [NUM_REQ-1:0]                 in_valid, ready, hold_vld, consume;

  assign in_data[0]  = bus.data0;
  assign in_data[1]  = bus.data1;
  assign in_valid[0] = bus.valid0;
  assign in_valid[1] = bus.valid1;
  assign bus.ready0  = ready[0];
  assign bus.ready1  = ready[1];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    uart_tx_hold_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data[i]),
      .in_valid   (in_valid[i]),
      .ready      (ready[i]),
      .consume    (consume[i]),
      .hold_valid (hold_vld[i]),
      .hold_data  (hold_data[i])
    );
  end

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  sel;
  logic                  tx_err_c;

  // Next-state: grant from IDLE, pulse in START, bounded wait for busy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    consume   = '0;
    sel       = REQ_CPU;
    tx_err_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|hold_vld) begin
          sel          = rr_pick(hold_vld, last_q);
          consume[sel] = 1'b1;
          tx_data_d    = hold_data[sel];
          grant_d      = sel;
          last_d       = sel;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never picked the byte up: drop it, no retry.
          tx_err_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      grant_q   <= REQ_CPU;
      last_q    <= REQ_DBG;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

  // Pulses are masked by rst so a reset kills them in the same cycle.
  assign bus.tx_start = (state_q == ST_START) && !rst;
  assign bus.tx_err   = tx_err_c && !rst;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = grant_q;
  assign bus.active   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: expected (byte, grant) pairs are queued as stimulus is
// driven and popped whenever the arbiter pulses tx_start.
module tb_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int BT = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW)) bus();

  uart_tx_arbiter #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, start_cyc = 0, err_cnt = 0, n_start = 0;
  int   busy_left = 0, busy_len = 10;
  bit   busy_en = 1'b1, rise_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Transmitter model plus output monitor, all on the falling edge.
  initial begin
    exp_t e;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rise_pend) begin
        bus.tx_busy = 1'b1;
        busy_left   = busy_len;
        rise_pend   = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end
      if (bus.tx_start) begin
        n_start++;
        start_cyc = cyc;
        if (sb.size() == 0) chk("unexp_start", 1, 0);
        else begin
          e = sb.pop_front();
          chk("tx_data", bus.tx_data, e.data);
          chk("grant_id", bus.grant_id, e.id);
        end
        if (busy_en) rise_pend = 1'b1;
      end
      if (bus.tx_err) begin
        err_cnt++;
        chk("err_lat", cyc - start_cyc, BT);
      end
    end
  end

  task automatic push(input bit idx, input logic [DW-1:0] d);
    int t = 0;
    @(negedge clk);
    if (idx) begin bus.data1 = d; bus.valid1 = 1'b1; end
    else     begin bus.data0 = d; bus.valid0 = 1'b1; end
    while (!(idx ? bus.ready1 : bus.ready0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("hs_timeout", t, 0);
    @(negedge clk);
    if (idx) bus.valid1 = 1'b0; else bus.valid0 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.valid0 = 1'b0;
    bus.valid1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready0", bus.ready0, 1);
    chk("rst_ready1", bus.ready1, 1);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_active", bus.active, 0);
    chk("rst_err", bus.tx_err, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_gid", bus.grant_id, 0);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((bus.active || bus.tx_busy || !bus.ready0 || !bus.ready1 || rise_pend) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, (t < 500), 1);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    int s0, e0, t;
    bus.data0 = '0; bus.valid0 = 1'b0;
    bus.data1 = '0; bus.valid1 = 1'b0;

    // Single byte with exact latency.
    do_reset();
    busy_en = 1'b1; busy_len = 10;
    sb.push_back('{8'h41, 1'b0});
    push(0, 8'h41);
    chk("single_ready0_full", bus.ready0, 0);
    chk("single_active_pre", bus.active, 0);
    @(negedge clk);
    chk("single_start_lat", bus.tx_start, 1);
    chk("single_ready0_ret", bus.ready0, 1);
    chk("single_active", bus.active, 1);
    wait_idle("single");

    // Tie right after reset: requester 0 first.
    do_reset();
    s0 = n_start;
    sb.push_back('{8'h11, 1'b0});
    sb.push_back('{8'h22, 1'b1});
    fork
      push(0, 8'h11);
      push(1, 8'h22);
    join
    wait_idle("tie");
    chk("tie_starts", n_start - s0, 2);

    // Sustained contention: strict alternation.
    do_reset();
    s0 = n_start;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{8'(8'hA0 + i), 1'b0});
      sb.push_back('{8'(8'hB0 + i), 1'b1});
    end
    fork
      begin for (int i = 0; i < 6; i++) push(0, 8'(8'hA0 + i)); end
      begin for (int j = 0; j < 6; j++) push(1, 8'(8'hB0 + j)); end
    join
    wait_idle("contend");
    chk("contend_starts", n_start - s0, 12);

    // Backpressure: second offer of 0x33 stalls until hold1 drains.
    do_reset();
    s0 = n_start;
    sb.push_back('{8'h50, 1'b0});
    sb.push_back('{8'h33, 1'b1});
    sb.push_back('{8'h33, 1'b1});
    push(0, 8'h50);
    @(negedge clk);
    bus.data1 = 8'h33; bus.valid1 = 1'b1;
    @(negedge clk);
    chk("bp_ready1_low", bus.ready1, 0);
    push(1, 8'h33);
    wait_idle("bp");
    chk("bp_starts", n_start - s0, 3);

    // Busy timeout: byte dropped, queued byte then goes normally.
    do_reset();
    busy_en = 1'b0;
    e0 = err_cnt;
    sb.push_back('{8'h5A, 1'b0});
    sb.push_back('{8'h6B, 1'b1});
    push(0, 8'h5A);
    push(1, 8'h6B);
    t = 0;
    while (err_cnt == e0 && t < 50) begin @(negedge clk); t++; end
    busy_en = 1'b1;
    chk("to_err_seen", (t < 50), 1);
    wait_idle("to");
    chk("to_err_once", err_cnt - e0, 1);

    // Reset in WAIT_DONE with hold1 full; the held byte is lost.
    do_reset();
    busy_len = 20;
    sb.push_back('{8'h71, 1'b0});
    push(0, 8'h71);
    push(1, 8'h72);
    t = 0;
    while (!bus.tx_busy && t < 50) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("mid_active", bus.active, 1);
    chk("mid_ready1", bus.ready1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_active", bus.active, 0);
    chk("mid_rst_ready0", bus.ready0, 1);
    chk("mid_rst_ready1", bus.ready1, 1);
    chk("mid_rst_start", bus.tx_start, 0);
    rst = 1'b0;
    chk("mid_sb_drained", sb.size(), 0);
    t = 0;
    while (bus.tx_busy && t < 100) begin @(negedge clk); t++; end
    chk("mid_busy_end", (t < 100), 1);
    sb.push_back('{8'h81, 1'b0});
    sb.push_back('{8'h82, 1'b1});
    fork
      push(0, 8'h81);
      push(1, 8'h82);
    join
    wait_idle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

endmodule
